// File: rtl/token_stream_parser.sv
// token_stream_parser: pulls ASCII bytes from a buffer with a 1-cycle read
// latency and splits them on delimiters into signed-decimal tokens. Each
// token is streamed char-by-char to the int32 converter. Lexical errors are
// latched with a code and the byte index of the offending char.
//
// Handshakes:
//   tok_valid/tok_ready: a char moves on the cycle tok_valid && tok_ready are
//   both high. While tok_ready is low, tok_valid, tok_char and tok_start hold
//   steady. tok_end is a one-cycle pulse that needs no acknowledge.
//   result_valid is counted only while waiting for a conversion and is
//   ignored at any other time.
module token_stream_parser #(
  parameter int MAX_PAYLOAD   = 2048,
  parameter int ADDR_W        = 16,
  parameter int CNT_W         = 11,
  parameter int MAX_TOKEN_LEN = 11,
  parameter bit ALLOW_COMMA   = 1'b1,
  parameter bit ALLOW_NEWLINE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              clear,
  input  logic [ADDR_W-1:0] total_length,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              tok_start,
  output logic [7:0]        tok_char,
  output logic              tok_valid,
  input  logic              tok_ready,
  output logic              tok_end,
  input  logic              result_valid,
  output logic [CNT_W-1:0]  num_count,
  output logic              parse_done,
  output logic              parse_error,
  output logic [1:0]        err_code,
  output logic [ADDR_W-1:0] err_pos
);

  localparam int                LEN_W   = $clog2(MAX_TOKEN_LEN + 1);
  localparam logic [ADDR_W-1:0] MAX_L   = ADDR_W'(MAX_PAYLOAD);
  localparam logic [LEN_W-1:0]  MAX_LEN = LEN_W'(MAX_TOKEN_LEN);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_CLASSIFY, S_EMIT, S_END_TOK, S_WAIT_CONV, S_DONE, S_ERR
  } state_t;

  // state_q is the observable FSM state for debug and bound checkers.
  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [7:0]          held_q, held_d;
  logic [ADDR_W-1:0]   lim_q, lim_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          code_q, code_d;
  logic [ADDR_W-1:0]   pos_q, pos_d;

  logic is_delim, is_digit, is_minus, at_end, lone_minus;

  // Character classes of the byte returned by the buffer.
  always_comb begin
    is_digit = (rd_data >= 8'h30) && (rd_data <= 8'h39);
    is_minus = (rd_data == 8'h2D);
    is_delim = (rd_data == 8'h20)
            || (ALLOW_COMMA && (rd_data == 8'h2C))
            || (ALLOW_NEWLINE && ((rd_data == 8'h0A) || (rd_data == 8'h0D)));
  end

  assign at_end     = (ptr_q >= lim_q);
  // A completed token consisting of just '-' carries no number.
  assign lone_minus = (len_q == LEN_W'(1)) && (held_q == 8'h2D);

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    held_d  = held_q;
    lim_d   = lim_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    pos_d   = pos_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          lim_d   = (total_length > MAX_L) ? MAX_L : total_length;
          ptr_d   = '0;
          len_d   = '0;
          cnt_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (at_end) state_d = (len_q != '0) ? S_END_TOK : S_DONE;
        else        state_d = S_CLASSIFY;
      end
      S_CLASSIFY: begin
        if (is_delim) begin
          if (len_q != '0) begin
            state_d = S_END_TOK;
          end else begin
            ptr_d   = ptr_q + 1'b1;
            state_d = S_REQ;
          end
        end else if (is_digit || (is_minus && (len_q == '0))) begin
          held_d  = rd_data;
          state_d = S_EMIT;
        end else begin
          code_d  = 2'd1;
          pos_d   = ptr_q;
          state_d = S_ERR;
        end
      end
      S_EMIT: begin
        if (tok_ready) begin
          if (len_q == MAX_LEN) begin
            code_d  = 2'd2;
            pos_d   = ptr_q;
            state_d = S_ERR;
          end else begin
            ptr_d   = ptr_q + 1'b1;
            len_d   = len_q + 1'b1;
            state_d = S_REQ;
          end
        end
      end
      S_END_TOK: begin
        if (lone_minus) begin
          code_d  = 2'd3;
          pos_d   = ptr_q - 1'b1;
          state_d = S_ERR;
        end else begin
          // Step over the terminating delimiter; at end of stream there is none.
          if (!at_end) ptr_d = ptr_q + 1'b1;
          len_d   = '0;
          state_d = S_WAIT_CONV;
        end
      end
      S_WAIT_CONV: begin
        if (result_valid) begin
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          state_d = S_REQ;
        end
      end
      S_DONE, S_ERR: state_d = state_q;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; clear behaves like a synchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      len_q   <= '0;
      held_q  <= '0;
      lim_q   <= '0;
      cnt_q   <= '0;
      code_q  <= '0;
      pos_q   <= '0;
    end else if (clear) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      len_q   <= '0;
      held_q  <= '0;
      lim_q   <= '0;
      cnt_q   <= '0;
      code_q  <= '0;
      pos_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      held_q  <= held_d;
      lim_q   <= lim_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      pos_q   <= pos_d;
    end
  end

  // Moore output decode from state and registers.
  always_comb begin
    rd_en       = (state_q == S_REQ) && !at_end;
    rd_addr     = rd_en ? ptr_q : '0;
    tok_valid   = (state_q == S_EMIT);
    tok_char    = tok_valid ? held_q : 8'h00;
    tok_start   = tok_valid && (len_q == '0);
    tok_end     = (state_q == S_END_TOK) && !lone_minus;
    num_count   = cnt_q;
    parse_done  = (state_q == S_DONE);
    parse_error = (state_q == S_ERR);
    err_code    = code_q;
    err_pos     = pos_q;
  end

endmodule

// File: tb/tb_token_stream_parser.sv
// Bench for token_stream_parser: two instances (default config, and a narrow
// config with comma/newline illegal, 4-char tokens, 16-byte payload), a
// buffer model, a converter responder and a reference tokenizer model.
module tb_token_stream_parser;

  localparam int ADDR_W = 16;
  localparam int CNT_W  = 11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, clear = 1'b0, sel = 1'b0;
  logic tok_ready = 1'b0, result_valid = 1'b0;
  logic [ADDR_W-1:0] total_length = '0;
  logic a_start, b_start;

  logic              a_rd_en, a_tok_start, a_tok_valid, a_tok_end, a_parse_done, a_parse_error;
  logic [ADDR_W-1:0] a_rd_addr, a_err_pos;
  logic [7:0]        a_rd_data, a_tok_char;
  logic [CNT_W-1:0]  a_num_count;
  logic [1:0]        a_err_code;
  logic              b_rd_en, b_tok_start, b_tok_valid, b_tok_end, b_parse_done, b_parse_error;
  logic [ADDR_W-1:0] b_rd_addr, b_err_pos;
  logic [7:0]        b_rd_data, b_tok_char;
  logic [CNT_W-1:0]  b_num_count;
  logic [1:0]        b_err_code;

  logic              m_rd_en, m_tok_start, m_tok_valid, m_tok_end, m_parse_done, m_parse_error;
  logic [ADDR_W-1:0] m_rd_addr, m_err_pos;
  logic [7:0]        m_tok_char;
  logic [CNT_W-1:0]  m_num_count;
  logic [1:0]        m_err_code;

  logic [7:0] mem [0:63];
  logic [8:0] exp_q[$];
  int exp_tokens, exp_err, exp_pos, exp_n;
  int n_cmp = 0;
  int n_err = 0;

  assign a_start = start & ~sel;
  assign b_start = start & sel;

  token_stream_parser dut_a (
    .clk(clk), .rst(rst), .start(a_start), .clear(clear), .total_length(total_length),
    .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
    .tok_start(a_tok_start), .tok_char(a_tok_char), .tok_valid(a_tok_valid),
    .tok_ready(tok_ready), .tok_end(a_tok_end), .result_valid(result_valid),
    .num_count(a_num_count), .parse_done(a_parse_done), .parse_error(a_parse_error),
    .err_code(a_err_code), .err_pos(a_err_pos)
  );

  token_stream_parser #(
    .MAX_PAYLOAD(16), .MAX_TOKEN_LEN(4), .ALLOW_COMMA(1'b0), .ALLOW_NEWLINE(1'b0)
  ) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .clear(clear), .total_length(total_length),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
    .tok_start(b_tok_start), .tok_char(b_tok_char), .tok_valid(b_tok_valid),
    .tok_ready(tok_ready), .tok_end(b_tok_end), .result_valid(result_valid),
    .num_count(b_num_count), .parse_done(b_parse_done), .parse_error(b_parse_error),
    .err_code(b_err_code), .err_pos(b_err_pos)
  );

  assign m_rd_en       = sel ? b_rd_en       : a_rd_en;
  assign m_rd_addr     = sel ? b_rd_addr     : a_rd_addr;
  assign m_tok_start   = sel ? b_tok_start   : a_tok_start;
  assign m_tok_char    = sel ? b_tok_char    : a_tok_char;
  assign m_tok_valid   = sel ? b_tok_valid   : a_tok_valid;
  assign m_tok_end     = sel ? b_tok_end     : a_tok_end;
  assign m_num_count   = sel ? b_num_count   : a_num_count;
  assign m_parse_done  = sel ? b_parse_done  : a_parse_done;
  assign m_parse_error = sel ? b_parse_error : a_parse_error;
  assign m_err_code    = sel ? b_err_code    : a_err_code;
  assign m_err_pos     = sel ? b_err_pos     : a_err_pos;

  // Clock.
  always #5 clk = ~clk;

  // Buffer read ports: data appears the cycle after rd_en.
  always @(posedge clk) begin
    if (a_rd_en) a_rd_data <= mem[a_rd_addr[5:0]];
    if (b_rd_en) b_rd_data <= mem[b_rd_addr[5:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit delim_ok(input logic [7:0] c, input bit ac, input bit an);
    return (c == 8'h20) || (ac && c == 8'h2C) || (an && (c == 8'h0A || c == 8'h0D));
  endfunction

  function automatic logic [7:0] rand_char();
    int r;
    r = $urandom_range(0, 99);
    if (r < 55)      return 8'h30 + 8'($urandom_range(0, 9));
    else if (r < 72) return 8'h20;
    else if (r < 79) return 8'h2C;
    else if (r < 83) return 8'h0A;
    else if (r < 86) return 8'h0D;
    else if (r < 95) return 8'h2D;
    else             return 8'h41 + 8'($urandom_range(0, 25));
  endfunction

  task automatic load_str(input string s);
    for (int i = 0; i < 64; i++) mem[i] = (i < s.len()) ? s[i] : 8'h20;
  endtask

  // Reference tokenizer: walks the first lim bytes, producing the expected
  // char stream ({start flag, char}), completed-token count and error.
  task automatic model(input int lim, input int maxt, input bit ac, input bit an);
    int tl;
    logic [7:0] c, first;
    exp_q.delete();
    exp_tokens = 0; exp_err = 0; exp_pos = 0; tl = 0; first = 8'h00;
    for (int i = 0; i < lim && exp_err == 0; i++) begin
      c = mem[i];
      if (delim_ok(c, ac, an)) begin
        if (tl > 0) begin
          if (tl == 1 && first == 8'h2D) begin exp_err = 3; exp_pos = i - 1; end
          else begin exp_tokens++; tl = 0; end
        end
      end else if ((c >= 8'h30 && c <= 8'h39) || (c == 8'h2D && tl == 0)) begin
        exp_q.push_back({tl == 0, c});
        if (tl == maxt) begin exp_err = 2; exp_pos = i; end
        else begin
          if (tl == 0) first = c;
          tl++;
        end
      end else begin
        exp_err = 1; exp_pos = i;
      end
    end
    if (exp_err == 0 && tl > 0) begin
      if (tl == 1 && first == 8'h2D) begin exp_err = 3; exp_pos = lim - 1; end
      else exp_tokens++;
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ":rd_en"},     32'(m_rd_en), 0);
    check({tag, ":rd_addr"},   32'(m_rd_addr), 0);
    check({tag, ":tok_valid"}, 32'(m_tok_valid), 0);
    check({tag, ":tok_start"}, 32'(m_tok_start), 0);
    check({tag, ":tok_char"},  32'(m_tok_char), 0);
    check({tag, ":tok_end"},   32'(m_tok_end), 0);
    check({tag, ":num_count"}, 32'(m_num_count), 0);
    check({tag, ":done"},      32'(m_parse_done), 0);
    check({tag, ":error"},     32'(m_parse_error), 0);
    check({tag, ":err_code"},  32'(m_err_code), 0);
    check({tag, ":err_pos"},   32'(m_err_pos), 0);
  endtask

  // mode 0: tok_ready high; 1: random tok_ready; 2: 5 stall cycles per char.
  task automatic run_case(input string tag, input bit use_b, input int tlen, input int mode);
    int lim, maxt, hs, ends, dly, stall_cnt, done_cyc;
    bit ac, an, pend, prev_stall, finished;
    logic [7:0] prev_char;
    logic [8:0] e;
    sel = use_b;
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    if (use_b) begin maxt = 4;  ac = 1'b0; an = 1'b0; lim = (tlen > 16) ? 16 : tlen; end
    else       begin maxt = 11; ac = 1'b1; an = 1'b1; lim = (tlen > 2048) ? 2048 : tlen; end
    model(lim, maxt, ac, an);
    exp_n = exp_q.size();
    hs = 0; ends = 0; pend = 1'b0; dly = 0; stall_cnt = 0; done_cyc = 0;
    prev_stall = 1'b0; prev_char = 8'h00; finished = 1'b0;
    total_length = 16'(tlen);
    start = 1'b1; tok_ready = 1'b0; result_valid = 1'b0;
    for (int cyc = 1; cyc <= 4000 && !finished; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        start = 1'b0;
        total_length = 16'($urandom);
      end
      if (prev_stall) begin
        check({tag, ":hold_valid"}, 32'(m_tok_valid), 1);
        check({tag, ":hold_char"},  32'(m_tok_char), 32'(prev_char));
      end
      if (m_rd_en) check({tag, ":rd_addr_range"}, 32'(int'(m_rd_addr) < lim), 1);
      case (mode)
        0: tok_ready = 1'b1;
        1: tok_ready = ($urandom_range(0, 9) < 7);
        default: begin
          if (m_tok_valid && stall_cnt < 5) begin tok_ready = 1'b0; stall_cnt++; end
          else tok_ready = m_tok_valid;
        end
      endcase
      if (m_tok_valid && tok_ready) begin
        hs++;
        stall_cnt = 0;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check({tag, ":char"}, 32'({m_tok_start, m_tok_char}), 32'(e));
        end else begin
          check({tag, ":extra_handshake"}, hs, exp_n);
        end
      end
      prev_stall = m_tok_valid && !tok_ready;
      prev_char  = m_tok_char;
      result_valid = 1'b0;
      if (pend) begin
        if (dly == 0) begin result_valid = 1'b1; pend = 1'b0; end
        else dly--;
      end else if (!m_tok_end && $urandom_range(0, 9) == 0) begin
        result_valid = 1'b1;
      end
      if (m_tok_end) begin ends++; pend = 1'b1; dly = $urandom_range(0, 3); end
      if (m_parse_done || m_parse_error) begin finished = 1'b1; done_cyc = cyc; end
    end
    result_valid = 1'b0;
    tok_ready = 1'b0;
    check({tag, ":finished"},  32'(finished), 1);
    check({tag, ":done"},      32'(m_parse_done), 32'(exp_err == 0));
    check({tag, ":error"},     32'(m_parse_error), 32'(exp_err != 0));
    check({tag, ":err_code"},  32'(m_err_code), exp_err);
    check({tag, ":err_pos"},   32'(m_err_pos), (exp_err != 0) ? exp_pos : 0);
    check({tag, ":num_count"}, 32'(m_num_count), exp_tokens);
    check({tag, ":tok_ends"},  ends, exp_tokens);
    check({tag, ":handshakes"}, hs, exp_n);
    if (lim == 0) check({tag, ":empty_latency"}, done_cyc, 2);
    @(negedge clk); @(negedge clk);
    check({tag, ":sticky_done"},  32'(m_parse_done), 32'(exp_err == 0));
    check({tag, ":sticky_error"}, 32'(m_parse_error), 32'(exp_err != 0));
  endtask

  task automatic dir_case(input string tag, input string s, input bit use_b, input int mode);
    load_str(s);
    run_case(tag, use_b, s.len(), mode);
  endtask

  // Abort a token mid-emit with rst or clear, then reparse from scratch.
  task automatic abort_case(input string tag, input bit use_rst);
    sel = 1'b0;
    load_str("123 4");
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    total_length = 16'd5; start = 1'b1; tok_ready = 1'b0;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 20 && !m_tok_valid; i++) @(negedge clk);
    check({tag, ":reach_emit"}, 32'(m_tok_valid), 1);
    if (use_rst) begin
      rst = 1'b1;
      #1;
      check_idle({tag, ":rst"});
      @(negedge clk); rst = 1'b0;
    end else begin
      clear = 1'b1;
      @(negedge clk); clear = 1'b0;
      check_idle({tag, ":clr"});
    end
    run_case({tag, ":reparse"}, 1'b0, 5, 1);
  endtask

  initial begin
    int n;
    bit ub;
    load_str("");
    repeat (3) @(negedge clk);
    check_idle("reset_hold");
    rst = 1'b0;
    @(negedge clk);
    check_idle("after_reset");

    dir_case("basic",      "12 -3 45", 1'b0, 0);
    dir_case("delims",     "  7,,8\n", 1'b0, 1);
    dir_case("no_comma",   "  7,,8\n", 1'b1, 0);
    dir_case("stall",      "95", 1'b0, 2);
    dir_case("mid_minus",  "1-2", 1'b0, 0);
    dir_case("lone_minus", "4 -", 1'b0, 0);
    dir_case("too_long",   "123456789012", 1'b0, 1);
    dir_case("max_len",    "12345678901", 1'b0, 0);
    dir_case("empty",      "", 1'b0, 0);
    dir_case("b_too_long", "12345", 1'b1, 0);
    dir_case("b_max_len",  "-123 4", 1'b1, 1);
    dir_case("b_clamp",    "1 2 3 4 5 6 7 8 9 1 2 3 4 5 6 7 8 9", 1'b1, 0);

    // clear has priority over start
    sel = 1'b0;
    load_str("5");
    @(negedge clk); clear = 1'b1; start = 1'b1; total_length = 16'd1;
    @(negedge clk); clear = 1'b0; start = 1'b0;
    check("clr_prio:rd_en", 32'(m_rd_en), 0);
    @(negedge clk);
    check("clr_prio:rd_en_late", 32'(m_rd_en), 0);
    check("clr_prio:done", 32'(m_parse_done), 0);

    abort_case("abort_rst", 1'b1);
    abort_case("abort_clr", 1'b0);

    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < 64; i++) mem[i] = rand_char();
      n  = $urandom_range(0, 48);
      ub = 1'($urandom_range(0, 1));
      run_case("rand", ub, n, $urandom_range(0, 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
